// File: rtl/mont_exp.sv
// Modular exponentiation controller: X^E mod M by sequencing an external
// Montgomery multiplier. Left-to-right square-and-multiply over e_len bits,
// with conversion into and out of the Montgomery domain.
module mont_exp #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned EW    = 512,
  parameter int unsigned LW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [EW-1:0]    in_e,
  input  logic [LW-1:0]    e_len,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_r2,
  input  logic [WIDTH-1:0] in_r,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
);

  typedef enum logic [2:0] {
    StIdle, StToMont, StCheck, StSquare, StMult, StFromMont, StDone
  } state_t;

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             waiting_q, waiting_d;
  logic [WIDTH-1:0] x_q, m_q, r2_q, r_q, xt_q, acc_q, result_q;
  logic [EW-1:0]    e_q, e_shift;
  logic [LW-1:0]    len_q, idx_q, len_clamped;
  logic             accept, capture, e_bit, mult_state;

  assign accept      = (state_q == StIdle) && start;
  // waiting_q is only ever set in a multiply state, so this is the capture strobe
  assign capture     = waiting_q && mm_done;
  assign len_clamped = (e_len > LW'(EW)) ? LW'(EW) : e_len;
  // idx_q was already decremented in CHECK, so this is the bit being squared for
  assign e_shift     = e_q >> idx_q;
  assign e_bit       = e_shift[0];
  assign mult_state  = (state_q == StToMont) || (state_q == StSquare) ||
                       (state_q == StMult) || (state_q == StFromMont);

  assign done   = (state_q == StDone);
  assign busy   = (state_q != StIdle);
  assign result = result_q;
  assign mm_m   = m_q;

  // State and handshake-phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waiting_q <= waiting_d;
    end
  end

  // Next state, operand select and multiplier start
  always_comb begin
    state_d   = state_q;
    waiting_d = waiting_q;
    mm_start  = 1'b0;
    mm_a      = '0;
    mm_b      = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StToMont;
      StToMont: begin
        mm_a = x_q;
        mm_b = r2_q;
        if (capture) state_d = StCheck;
      end
      StCheck: state_d = (idx_q == '0) ? StFromMont : StSquare;
      StSquare: begin
        mm_a = acc_q;
        mm_b = acc_q;
        if (capture) state_d = e_bit ? StMult : StCheck;
      end
      StMult: begin
        mm_a = acc_q;
        mm_b = xt_q;
        if (capture) state_d = StCheck;
      end
      StFromMont: begin
        mm_a = acc_q;
        mm_b = One;
        if (capture) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // First cycle of a multiply state issues; the rest wait for mm_done
    if (mult_state) begin
      if (!waiting_q) begin
        mm_start  = 1'b1;
        waiting_d = 1'b1;
      end else if (mm_done) begin
        waiting_d = 1'b0;
      end
    end
  end

  // Input capture, working registers and result
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      e_q      <= '0;
      len_q    <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      r_q      <= '0;
      xt_q     <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        x_q   <= in_x;
        e_q   <= in_e;
        len_q <= len_clamped;
        m_q   <= in_m;
        r2_q  <= in_r2;
        r_q   <= in_r;
      end
      if (capture) begin
        unique case (state_q)
          StToMont: begin
            xt_q  <= mm_result;
            acc_q <= r_q;
            idx_q <= len_q;
          end
          StSquare, StMult: acc_q    <= mm_result;
          StFromMont:       result_q <= mm_result;
          default: ;
        endcase
      end
      if ((state_q == StCheck) && (idx_q != '0)) idx_q <= idx_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_mont_exp.sv
// Self-checking bench for mont_exp with a behavioural Montgomery multiplier
// and a plain-arithmetic modular exponentiation reference.
module tb_mont_exp;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [511:0] in_x, in_e, in_m, in_r2, in_r, result;
  logic [511:0] mm_a, mm_b, mm_m, mm_result;
  logic [9:0]   e_len;
  logic         done, busy, mm_start, mm_done;

  int checks = 0;
  int errors = 0;
  int nstart = 0;

  mont_exp #(.WIDTH(512), .EW(512), .LW(10)) dut (
    .clk(clk), .reset(reset), .start(start), .in_x(in_x), .in_e(in_e), .e_len(e_len),
    .in_m(in_m), .in_r2(in_r2), .in_r(in_r), .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_result(mm_result),
    .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // a*b*2^-512 mod m, bit-serial
  function automatic logic [511:0] mont(input logic [511:0] a, b, m);
    logic [513:0] t = '0;
    for (int i = 0; i < 512; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[511:0];
  endfunction

  function automatic logic [511:0] modmul(input logic [511:0] a, b, m);
    logic [1023:0] p;
    p = {512'd0, a} * {512'd0, b};
    p = p % {512'd0, m};
    return p[511:0];
  endfunction

  function automatic logic [511:0] rmod(input logic [511:0] m);
    logic [1023:0] big = '0;
    big[512] = 1'b1;
    big = big % {512'd0, m};
    return big[511:0];
  endfunction

  // Right-to-left binary exponentiation over the low len bits of e
  function automatic logic [511:0] modpow(input logic [511:0] x, e, m, input int len);
    logic [511:0] r, b;
    r = 512'd1 % m;
    b = x % m;
    for (int i = 0; i < len; i++) begin
      if (e[i]) r = modmul(r, b, m);
      b = modmul(b, b, m);
    end
    return r;
  endfunction

  // Multiplier model: latches operands on mm_start, answers after 1..4 cycles,
  // and checks operands stay put while the controller waits.
  initial begin
    logic [511:0] la, lb, lm;
    int  cnt;
    bit  pend, prev_start;
    mm_done = 1'b0; mm_result = '0; pend = 1'b0; prev_start = 1'b0; cnt = 0;
    la = '0; lb = '0; lm = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (pend) begin
        if (busy && !mm_start) begin
          chk("mm_a stable", mm_a, la);
          chk("mm_b stable", mm_b, lb);
        end
        cnt--;
        if (cnt == 0) begin
          mm_done   = 1'b1;
          mm_result = mont(la, lb, lm);
          pend      = 1'b0;
        end
      end
      if (mm_start) begin
        if (prev_start) chk("mm_start one cycle", 512'(0), 512'(1));
        la = mm_a; lb = mm_b; lm = mm_m;
        cnt = $urandom_range(1, 4);
        pend = 1'b1;
        nstart++;
      end
      prev_start = mm_start;
    end
  end

  task automatic run(input string tag, input logic [511:0] x, e, m, input int len,
                     input bit disturb);
    int eff, exp_n, base, cyc;
    bit got, busy_ok, poked;
    logic [511:0] r, expv;
    eff   = (len > 512) ? 512 : len;
    exp_n = 2 + eff;
    for (int i = 0; i < eff; i++) exp_n += int'(e[i]);
    r     = rmod(m);
    expv  = modpow(x, e, m, eff);
    @(negedge clk);
    base  = nstart;
    in_x = x; in_e = e; in_m = m; in_r = r; in_r2 = modmul(r, r, m);
    e_len = 10'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_x = rnd(); in_e = rnd(); in_m = rnd(); in_r = rnd(); in_r2 = rnd();
    e_len = 10'($urandom);
    chk({tag, " first mm_start"}, 512'(mm_start), 512'(1));
    chk({tag, " busy after start"}, 512'(busy), 512'(1));
    got = 1'b0; busy_ok = 1'b1; poked = 1'b0; cyc = 0;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (disturb && !poked && (nstart - base) >= 2) begin
        start = 1'b1; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, " done seen"}, 512'(got), 512'(1));
    chk({tag, " busy held"}, 512'(busy_ok), 512'(1));
    chk({tag, " busy at done"}, 512'(busy), 512'(1));
    chk({tag, " result"}, result, expv);
    chk({tag, " mm count"}, 512'(nstart - base), 512'(exp_n));
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done one cycle"}, 512'(done), 512'(0));
    chk({tag, " idle after done"}, 512'(busy), 512'(0));
    chk({tag, " result held"}, result, expv);
  endtask

  initial begin
    logic [511:0] m, x, e;
    int  base, cyc;
    bit  ok;
    reset = 1'b1; start = 1'b0; e_len = '0;
    in_x = '0; in_e = '0; in_m = '0; in_r2 = '0; in_r = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset done", 512'(done), 512'(0));
    chk("reset busy", 512'(busy), 512'(0));
    chk("reset mm_start", 512'(mm_start), 512'(0));
    chk("reset result", result, 512'(0));
    chk("reset mm_a", mm_a, 512'(0));
    chk("reset mm_b", mm_b, 512'(0));

    run("x3e5m7", 512'd3, 512'd5, 512'd7, 3, 1'b0);
    chk("x3e5m7 literal", result, 512'd5);
    run("x2e10", 512'd2, 512'd10, 512'd1000003, 4, 1'b0);
    chk("x2e10 literal", result, 512'd1024);

    m = rnd(); m[0] = 1'b1; m[511] = 1'b1;
    x = rnd() % m;
    run("e1011 rand", x, 512'hB, m, 4, 1'b0);
    run("elen0", 512'd5, 512'd0, 512'd13, 0, 1'b0);
    run("elen0 ff", 512'd5, 512'hFF, 512'd13, 0, 1'b0);
    run("m1", 512'd0, 512'd7, 512'd1, 0, 1'b0);

    m = rnd(); m[0] = 1'b1;
    x = rnd() % m;
    e = rnd();
    run("rand16 disturb", x, e, m, 16, 1'b1);
    run("clamp", x, e, m, 1023, 1'b0);

    // Reset in the middle of the third multiplication
    m = rnd(); m[0] = 1'b1; m[511] = 1'b1;
    x = rnd() % m;
    e = rnd();
    @(negedge clk);
    base = nstart;
    in_x = x; in_e = e; in_m = m; in_r = rmod(m); in_r2 = modmul(in_r, in_r, m);
    e_len = 10'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((nstart - base) < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("third mm reached", 512'((nstart - base) >= 3), 512'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst done", 512'(done), 512'(0));
    chk("midrst busy", 512'(busy), 512'(0));
    chk("midrst mm_start", 512'(mm_start), 512'(0));
    chk("midrst result", result, 512'(0));
    chk("midrst mm_a", mm_a, 512'(0));
    chk("midrst mm_b", mm_b, 512'(0));
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) ok = 1'b0;
    end
    chk("stale mm_done ignored", 512'(ok), 512'(1));
    run("after reset", x, e, m, 40, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
